mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
Iterative shift-add unsigned multiplier controller for the EX stage of the pipelined MIPS core. It accepts an operand pair from EX and sequences WIDTH add/shift iterations through its own accumulator. It holds the pipeline via `stall` until the product is ready, and exports the ALU control code of each step for trace and debug. A pipeline flush aborts an operation in flight.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits; legal values 4..64.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request a multiply; sampled in IDLE or DONE.
- flush, input, 1, pipeline flush; aborts the current operation.
- op_a, input, WIDTH, multiplicand (unsigned).
- op_b, input, WIDTH, multiplier (unsigned).
- busy, output, 1, high in RUN.
- stall, output, 1, hold request to the hazard unit.
- done, output, 1, one-cycle pulse; product valid.
- product, output, 2*WIDTH, result register.
- alu_ctrl_o, output, 4, ALU control code of the current step.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, product=0, done=0, busy=0.
  - All internal operand registers cleared.
  - Takes effect immediately, including mid-RUN. No done pulse follows.
- States: IDLE, RUN, DONE. State is registered; outputs are decoded from state, except `stall`.
- IDLE:
  - flush=1: stay IDLE.
  - start=1 and (op_a==0 or op_b==0): next=DONE, product<=0 (zero fast path, 1-cycle latency).
  - start=1 otherwise: latch op_a into mcand (2*WIDTH, zero-extended), op_b into mplier, acc<=0, cnt<=0, next=RUN.
  - start=0: stay IDLE.
- RUN, at each edge:
  - If mplier[0]=1: acc<=acc+mcand.
  - mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge: product<=final acc value (including that edge's add), next=DONE.
  - Additions are 2*WIDTH bits wide; overflow is impossible by construction.
- DONE:
  - done=1 for exactly this cycle; product is valid and held until the next accepted operation completes.
  - start is handled exactly as in IDLE, which allows back-to-back operations. Otherwise next=IDLE.
- flush in RUN or DONE:
  - next=IDLE; product keeps its previous value; no further done pulse.
  - flush overrides a simultaneous start.
- Latency: the start edge is edge 0; done is high in the cycle after edge WIDTH, giving WIDTH+1 cycles (1 cycle on the zero fast path).
- Outputs:
  - busy = (state==RUN).
  - stall = (state==RUN) | (start & ~flush & state!=RUN). This is combinational, so the pipeline is held in the request cycle itself. stall=0 in the DONE cycle unless a new start is present.
- alu_ctrl_o:
  - IDLE or DONE: 4'b1000 (pass_aluA).
  - RUN with mplier[0]=1: 4'b0000 (ADD).
  - RUN with mplier[0]=0: 4'b0111 (SRL, shift only).
- cnt width: $clog2(WIDTH) bits. It reaches WIDTH-1 at most and never wraps.
- start while busy is ignored. The issuing stage holds start and operands stable while stall=1.

Test Plan:
- Reset: hold rst_n=0 mid-RUN of 7*9 -> busy=0, done=0, product=0 and state IDLE asynchronously (before the next clk edge); no done pulse after release.
- Basic: op_a=3, op_b=5, one start pulse -> stall=1 for cycles 0..32, done=1 in cycle 33, product=64'h000000000000000F.
- Max operands: op_a=op_b=32'hFFFFFFFF -> done after 33 cycles, product=64'hFFFFFFFE00000001; alu_ctrl_o=0000 in every RUN cycle.
- Zero fast path: op_a=0, op_b=32'h1234 -> done in the cycle after start, product=0, busy never asserted. Then repeat with op_a=32'h1234, op_b=0 -> same result.
- Flush: start 6*7, assert flush on RUN cycle 10 -> IDLE next cycle, no done, product keeps its prior value. Flush+start together in IDLE -> no operation accepted, stall=0.
- Back-to-back: start held in the DONE cycle with 2*3 after 4*5 -> done for 20, then the next done 33 cycles later with product=6. Check alu_ctrl_o for op_b=5 (binary 101): ADD, SRL, ADD, then SRL for the remaining iterations.

Source files
------------

// File: rtl/mul_sequencer.sv
// Iterative shift-add unsigned multiplier for the EX stage: one add/shift step per
// cycle over WIDTH cycles, holding the pipeline via stall until the product is ready.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 stall,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [3:0]           alu_ctrl_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_PASS = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [WIDTH-1:0]     mplier;
  logic                 accept;
  logic                 zero_op;
  logic                 last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = start & ~flush & (state != RUN);
    zero_op    = (op_a == '0) | (op_b == '0);
    last       = (state == RUN) & (cnt == CNT_W'(WIDTH - 1));
    acc_sum    = mplier[0] ? (acc + mcand) : acc;
    busy       = (state == RUN);
    done       = (state == DONE);
    // stall covers the request cycle itself so EX never advances past an accepted start
    stall      = busy | accept;
    alu_ctrl_o = ALU_PASS;
    if (state == RUN) begin
      alu_ctrl_o = mplier[0] ? ALU_ADD : ALU_SRL;
    end

    case (state)
      IDLE, DONE: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt = zero_op ? DONE : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (last) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (zero_op) begin
              product <= '0;
            end else begin
              mcand  <= {{WIDTH{1'b0}}, op_a};
              mplier <= op_b;
              acc    <= '0;
              cnt    <= '0;
            end
          end
        end
        RUN: begin
          if (!flush) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            // hold cnt at its terminal value so it never wraps
            if (last) begin
              product <= acc_sum;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: transaction-level model compared every cycle,
// plus directed operations with hand-computed latencies and products.
module tb_mul_sequencer;

  localparam int W = 32;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             flush;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic             busy;
  logic             stall;
  logic             done;
  logic [2*W-1:0]   product;
  logic [3:0]       alu_ctrl_o;

  int checks   = 0;
  int failures = 0;

  mul_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .flush      (flush),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .product    (product),
    .alu_ctrl_o (alu_ctrl_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted op at cycle t0 runs in cycles t0+1..t0+W and
  // reports done in cycle t0+W+1 (t0+1 if either operand is zero).
  int               cyc = 0;
  bit               have_op = 0;
  int               t0 = 0;
  int               lat = 0;
  logic [W-1:0]     mb = '0;
  logic [2*W-1:0]   pend = '0;
  logic [2*W-1:0]   exp_prod = '0;

  always @(negedge clk) begin
    bit inrun, indone;
    logic [3:0] exp_alu;
    if (!rst_n) begin
      have_op  = 0;
      exp_prod = '0;
    end
    inrun  = have_op && (lat > 1) && (cyc > t0) && (cyc <= t0 + W);
    indone = have_op && (cyc == t0 + lat);
    if (indone) exp_prod = pend;
    exp_alu = 4'b1000;
    if (inrun) exp_alu = mb[cyc - t0 - 1] ? 4'b0000 : 4'b0111;

    chk("m_busy",    {63'd0, busy},  {63'd0, inrun});
    chk("m_done",    {63'd0, done},  {63'd0, indone});
    chk("m_stall",   {63'd0, stall}, {63'd0, inrun | (start & ~flush & ~inrun)});
    chk("m_product", product, exp_prod);
    chk("m_alu",     {60'd0, alu_ctrl_o}, {60'd0, exp_alu});

    if (rst_n) begin
      if (flush) begin
        have_op = 0;
      end else if (start && !inrun) begin
        have_op = 1;
        t0      = cyc;
        mb      = op_b;
        pend    = 64'(op_a) * 64'(op_b);
        lat     = ((op_a == '0) || (op_b == '0)) ? 1 : W + 1;
      end else if (indone) begin
        have_op = 0;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
  endtask

  task automatic wait_done(output int n, output int adds, output bit busy_seen);
    n = 0;
    adds = 0;
    busy_seen = 0;
    while (n < 200) begin
      @(negedge clk);
      if (busy) busy_seen = 1;
      if (busy && alu_ctrl_o == 4'b0000) adds++;
      if (done) break;
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end
    if (n >= 200) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic watch_no_done(input int ncyc, output bit seen);
    seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n, adds;
    bit bseen, dseen;

    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op_a  = '0;
    op_b  = '0;
    #2;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_alu", {60'd0, alu_ctrl_o}, 64'h8);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // basic 3*5, op_b=101b gives ADD,SRL,ADD then SRL
    do_op(32'd3, 32'd5);
    wait_done(n, adds, bseen);
    chk("basic_lat", 64'(n), 64'd33);
    chk("basic_prod", product, 64'h000000000000000F);
    chk("basic_adds", 64'(adds), 64'd2);
    step();

    // flush on RUN cycle 10 of 6*7
    do_op(32'd6, 32'd7);
    step();
    start = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {63'd0, busy}, 64'd0);
    step();
    watch_no_done(40, dseen);
    chk("flush_no_done", {63'd0, dseen}, 64'd0);
    chk("flush_prod_kept", product, 64'h000000000000000F);

    // flush together with start in IDLE
    do_op(32'd2, 32'd2);
    flush = 1'b1;
    @(negedge clk);
    chk("fs_stall", {63'd0, stall}, 64'd0);
    step();
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("fs_busy", {63'd0, busy}, 64'd0);
    chk("fs_done", {63'd0, done}, 64'd0);
    step();

    // maximum operands
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n, adds, bseen);
    chk("max_lat", 64'(n), 64'd33);
    chk("max_prod", product, 64'hFFFFFFFE00000001);
    chk("max_adds", 64'(adds), 64'd32);
    step();

    // zero fast path, both operand positions
    do_op(32'd0, 32'h1234);
    wait_done(n, adds, bseen);
    chk("zeroa_lat", 64'(n), 64'd1);
    chk("zeroa_prod", product, 64'd0);
    chk("zeroa_busy", {63'd0, bseen}, 64'd0);
    step();
    do_op(32'h1234, 32'd0);
    wait_done(n, adds, bseen);
    chk("zerob_lat", 64'(n), 64'd1);
    chk("zerob_prod", product, 64'd0);
    chk("zerob_busy", {63'd0, bseen}, 64'd0);
    step();

    // back-to-back: 4*5 then 2*3 issued in the DONE cycle
    do_op(32'd4, 32'd5);
    step();
    start = 1'b0;
    repeat (32) step();
    do_op(32'd2, 32'd3);
    @(negedge clk);
    chk("b2b_done1", {63'd0, done}, 64'd1);
    chk("b2b_prod1", product, 64'd20);
    chk("b2b_stall", {63'd0, stall}, 64'd1);
    step();
    start = 1'b0;
    wait_done(n, adds, bseen);
    chk("b2b_lat2", 64'(n), 64'd32);
    chk("b2b_prod2", product, 64'd6);
    chk("b2b_adds2", 64'(adds), 64'd2);
    step();

    // asynchronous reset mid-RUN of 7*9
    do_op(32'd7, 32'd9);
    step();
    start = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #2;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_prod", product, 64'd0);
    chk("arst_alu", {60'd0, alu_ctrl_o}, 64'h8);
    repeat (2) step();
    rst_n = 1'b1;
    watch_no_done(40, dseen);
    chk("arst_no_done", {63'd0, dseen}, 64'd0);
    chk("arst_prod_after", product, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
